// File: rtl/data_memory_interface_if.sv
// Data-memory bus between the load/store unit (master) and the memory (slave).
interface data_memory_interface_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      input  dmem_ack, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      output dmem_ack, dmem_rdata
   );
endinterface

// File: rtl/data_memory_interface.sv
// Load/store unit: req/ack data-memory handshake, load extension, PC stall and
// misalignment / illegal-size / timeout fault reporting.
module data_memory_interface #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int TIMEOUT_WIDTH  = 5
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           memory_read,
   input  logic                           memory_write,
   input  logic [2:0]                     funct3,
   input  logic [31:0]                    address,
   input  logic [31:0]                    store_data,
   data_memory_interface_if.master        bus,
   output logic [31:0]                    load_data,
   output logic                           write_done,
   output logic                           addr_misaligned,
   output logic                           access_fault
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] DONE   = 2'd2;
   localparam logic [TIMEOUT_WIDTH-1:0] LAST_WAIT = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

   logic [1:0]               state;
   logic [TIMEOUT_WIDTH-1:0] wait_count;
   logic                     fault_q;
   logic                     request;
   logic                     size_illegal;
   logic                     misaligned;
   logic                     start;
   logic [7:0]               lane_byte;
   logic [15:0]              lane_half;
   logic [31:0]              extended;

   // A store takes priority over a simultaneous load, so legality follows the store rules then.
   always_comb begin
      request = memory_read | memory_write;
      if (memory_write)
         size_illegal = funct3[2] | (funct3[1:0] == 2'b11);
      else
         size_illegal = (funct3[1:0] == 2'b11) | (funct3 == 3'b110);
      misaligned = ((funct3[1:0] == 2'b01) & address[0]) |
                   ((funct3[1:0] == 2'b10) & (address[1:0] != 2'b00));
      start = (state == IDLE) & request & ~size_illegal & ~misaligned;
   end

   always_comb begin
      bus.dmem_req  = (state == ACCESS);
      bus.dmem_we   = (state == ACCESS) & memory_write;
      bus.dmem_addr = {address[31:2], 2'b00};
      bus.dmem_be   = 4'b1111;
      if (memory_write) begin
         case (funct3[1:0])
            2'b00:   bus.dmem_be = 4'b0001 << address[1:0];
            2'b01:   bus.dmem_be = address[1] ? 4'b1100 : 4'b0011;
            default: bus.dmem_be = 4'b1111;
         endcase
      end
      case (funct3[1:0])
         2'b00:   bus.dmem_wdata = {4{store_data[7:0]}};
         2'b01:   bus.dmem_wdata = {2{store_data[15:0]}};
         default: bus.dmem_wdata = store_data;
      endcase
      write_done      = ~(start | (state == ACCESS));
      addr_misaligned = (state == IDLE) & request & ~size_illegal & misaligned;
      access_fault    = ((state == IDLE) & request & size_illegal) |
                        ((state == DONE) & fault_q);
   end

   always_comb begin
      case (address[1:0])
         2'b00:   lane_byte = bus.dmem_rdata[7:0];
         2'b01:   lane_byte = bus.dmem_rdata[15:8];
         2'b10:   lane_byte = bus.dmem_rdata[23:16];
         default: lane_byte = bus.dmem_rdata[31:24];
      endcase
      lane_half = address[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
      case (funct3)
         3'b000:  extended = {{24{lane_byte[7]}}, lane_byte};
         3'b001:  extended = {{16{lane_half[15]}}, lane_half};
         3'b100:  extended = {24'd0, lane_byte};
         3'b101:  extended = {16'd0, lane_half};
         default: extended = bus.dmem_rdata;
      endcase
   end

   // An ack arriving in the final wait cycle completes normally rather than timing out.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         load_data  <= 32'd0;
         wait_count <= '0;
         fault_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               fault_q <= 1'b0;
               if (start) begin
                  state      <= ACCESS;
                  wait_count <= '0;
               end
            end
            ACCESS: begin
               if (bus.dmem_ack) begin
                  if (!memory_write)
                     load_data <= extended;
                  state <= DONE;
               end else if (wait_count == LAST_WAIT) begin
                  state     <= DONE;
                  fault_q   <= 1'b1;
                  load_data <= 32'd0;
               end else begin
                  wait_count <= wait_count + TIMEOUT_WIDTH'(1);
               end
            end
            DONE: begin
               state   <= IDLE;
               fault_q <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_memory_interface.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and
// randomized accesses checked against a behavioural load/store model.
module tb_data_memory_interface;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        memory_read;
   logic        memory_write;
   logic [2:0]  funct3;
   logic [31:0] address;
   logic [31:0] store_data;
   logic [31:0] load_data;
   logic        write_done;
   logic        addr_misaligned;
   logic        access_fault;

   int          checks = 0;
   int          errors = 0;
   int          req_cycles;
   logic [31:0] last_load;

   data_memory_interface_if bus();

   data_memory_interface dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .memory_read    (memory_read),
      .memory_write   (memory_write),
      .funct3         (funct3),
      .address        (address),
      .store_data     (store_data),
      .bus            (bus),
      .load_data      (load_data),
      .write_done     (write_done),
      .addr_misaligned(addr_misaligned),
      .access_fault   (access_fault)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] sd;
      logic [31:0] rdata;
      int          waits;
      logic        exp_mis;
      logic        exp_fault;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
      logic [31:0] exp_load;
   } vec_t;

   vec_t vecs[$];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] sd,
                               input logic [31:0] rdata, input int waits,
                               input logic mis, input logic fault, input logic [3:0] be,
                               input logic [31:0] wdata, input logic [31:0] ld);
      vec_t v;
      v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.sd = sd; v.rdata = rdata;
      v.waits = waits; v.exp_mis = mis; v.exp_fault = fault; v.exp_be = be;
      v.exp_wdata = wdata; v.exp_load = ld;
      return v;
   endfunction

   // Reference model: access size in bytes, legality lists and arithmetic lane extraction.
   function automatic vec_t model(input vec_t v);
      int     size;
      int     off;
      longint val;
      longint full;
      logic   legal;
      size  = 1 << v.f3[1:0];
      off   = int'(v.addr % 4);
      legal = v.wr ? (v.f3 inside {0, 1, 2}) : (v.f3 inside {0, 1, 2, 4, 5});
      v.exp_fault = !legal;
      v.exp_mis   = legal && ((v.addr % size) != 0);
      v.exp_be    = 4'hF;
      if (v.wr && size < 4)
         v.exp_be = 4'(((1 << size) - 1) << off);
      if (size == 1)      v.exp_wdata = (v.sd % 256) * 32'h01010101;
      else if (size == 2) v.exp_wdata = (v.sd % 65536) * 32'h00010001;
      else                v.exp_wdata = v.sd;
      val = longint'(v.rdata) >> (8 * off);
      if (size < 4) begin
         full = longint'(1) << (8 * size);
         val  = val % full;
         if (!v.f3[2] && val >= full / 2)
            val = val - full;
      end
      v.exp_load = val[31:0];
      return v;
   endfunction

   task automatic applyStimulus(input vec_t v);
      logic        legal;
      logic [31:0] exp_load;
      @(negedge clk);
      memory_read  = v.rd;
      memory_write = v.wr;
      funct3       = v.f3;
      address      = v.addr;
      store_data   = v.sd;
      bus.dmem_ack   = 1'b0;
      bus.dmem_rdata = $urandom;
      #1;
      checkOutput("addr_misaligned", addr_misaligned, v.exp_mis);
      checkOutput("access_fault_idle", access_fault, v.exp_fault);
      legal = !(v.exp_mis || v.exp_fault);
      checkOutput("write_done_idle", write_done, !legal);
      checkOutput("dmem_req_idle", bus.dmem_req, 0);
      if (legal) begin
         for (int c = 0; c <= v.waits; c++) begin
            @(negedge clk);
            bus.dmem_ack   = (c == v.waits);
            bus.dmem_rdata = (c == v.waits) ? v.rdata : $urandom;
            #1;
            checkOutput("dmem_req_access", bus.dmem_req, 1);
            checkOutput("write_done_access", write_done, 0);
            checkOutput("dmem_we", bus.dmem_we, v.wr);
            checkOutput("dmem_addr", bus.dmem_addr, v.addr & 32'hFFFF_FFFC);
            checkOutput("dmem_be", bus.dmem_be, v.exp_be);
            if (v.wr)
               checkOutput("dmem_wdata", bus.dmem_wdata, v.exp_wdata);
         end
         @(negedge clk);
         bus.dmem_ack = 1'b0;
         #1;
         exp_load = v.wr ? last_load : v.exp_load;
         checkOutput("write_done_done", write_done, 1);
         checkOutput("dmem_req_done", bus.dmem_req, 0);
         checkOutput("access_fault_done", access_fault, 0);
         checkOutput("load_data", load_data, exp_load);
         last_load = exp_load;
      end
      @(negedge clk);
      memory_read  = 1'b0;
      memory_write = 1'b0;
      #1;
      checkOutput("write_done_after", write_done, 1);
      checkOutput("dmem_req_after", bus.dmem_req, 0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t v;
      int   op;
      reset_n = 1'b0;
      memory_read = 1'b0; memory_write = 1'b0; funct3 = 3'b000;
      address = 32'd0; store_data = 32'd0;
      bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'd0;
      last_load = 32'd0;
      repeat (2) @(negedge clk);
      #1;
      checkOutput("reset_load_data", load_data, 0);
      checkOutput("reset_dmem_req", bus.dmem_req, 0);
      checkOutput("reset_write_done", write_done, 1);
      checkOutput("reset_access_fault", access_fault, 0);
      @(negedge clk);
      reset_n = 1'b1;

      vecs.push_back(mk(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 0, 4'hF, 32'h0, 32'hDEADBEEF));
      vecs.push_back(mk(1, 0, 3'b000, 32'h203, 32'h0, 32'h80FFFF12, 0, 0, 0, 4'hF, 32'h0, 32'hFFFFFF80));
      vecs.push_back(mk(1, 0, 3'b100, 32'h203, 32'h0, 32'h80FFFF12, 0, 0, 0, 4'hF, 32'h0, 32'h00000080));
      vecs.push_back(mk(0, 1, 3'b001, 32'h302, 32'h0000ABCD, 32'h0, 3, 0, 0, 4'hC, 32'hABCDABCD, 32'h0));
      vecs.push_back(mk(1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 1, 0, 4'hF, 32'h0, 32'h0));
      vecs.push_back(mk(1, 0, 3'b001, 32'h202, 32'h0, 32'h80011234, 1, 0, 0, 4'hF, 32'h0, 32'hFFFF8001));
      vecs.push_back(mk(1, 0, 3'b101, 32'h200, 32'h0, 32'h8001F234, 0, 0, 0, 4'hF, 32'h0, 32'h0000F234));
      vecs.push_back(mk(0, 1, 3'b000, 32'h401, 32'h12345678, 32'h0, 0, 0, 0, 4'h2, 32'h78787878, 32'h0));
      vecs.push_back(mk(0, 1, 3'b010, 32'h500, 32'hCAFEBABE, 32'h0, 1, 0, 0, 4'hF, 32'hCAFEBABE, 32'h0));
      vecs.push_back(mk(1, 0, 3'b011, 32'h600, 32'h0, 32'h0, 0, 0, 1, 4'hF, 32'h0, 32'h0));
      vecs.push_back(mk(0, 1, 3'b100, 32'h604, 32'h0, 32'h0, 0, 0, 1, 4'hF, 32'h0, 32'h0));
      vecs.push_back(mk(1, 1, 3'b100, 32'h608, 32'h0, 32'h0, 0, 0, 1, 4'hF, 32'h0, 32'h0));
      vecs.push_back(mk(1, 1, 3'b010, 32'h504, 32'h13572468, 32'h0, 0, 0, 0, 4'hF, 32'h13572468, 32'h0));
      vecs.push_back(mk(1, 0, 3'b001, 32'h203, 32'h0, 32'h0, 0, 1, 0, 4'hF, 32'h0, 32'h0));
      vecs.push_back(mk(0, 1, 3'b010, 32'h502, 32'h0, 32'h0, 0, 1, 0, 4'hF, 32'h0, 32'h0));
      vecs.push_back(mk(1, 0, 3'b000, 32'h001, 32'h0, 32'h00007F00, 2, 0, 0, 4'hF, 32'h0, 32'h0000007F));
      vecs.push_back(mk(1, 0, 3'b010, 32'h700, 32'h0, 32'h11223344, 15, 0, 0, 4'hF, 32'h0, 32'h11223344));
      foreach (vecs[i]) applyStimulus(vecs[i]);

      $display("[TB] ack outside ACCESS");
      @(negedge clk);
      bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h5555AAAA;
      #1;
      checkOutput("idle_ack_req", bus.dmem_req, 0);
      @(negedge clk);
      bus.dmem_ack = 1'b0;
      #1;
      checkOutput("idle_ack_load_data", load_data, last_load);
      checkOutput("idle_ack_write_done", write_done, 1);

      $display("[TB] store timeout");
      @(negedge clk);
      memory_write = 1'b1; funct3 = 3'b010; address = 32'h600; store_data = 32'h0BADF00D;
      #1;
      checkOutput("timeout_write_done_idle", write_done, 0);
      req_cycles = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         #1;
         if (bus.dmem_req) req_cycles++;
         else break;
      end
      checkOutput("timeout_req_cycles", req_cycles, 16);
      checkOutput("timeout_access_fault", access_fault, 1);
      checkOutput("timeout_write_done", write_done, 1);
      checkOutput("timeout_load_data", load_data, 0);
      last_load = 32'd0;
      @(negedge clk);
      memory_write = 1'b0;
      #1;
      checkOutput("timeout_fault_cleared", access_fault, 0);
      checkOutput("timeout_idle_req", bus.dmem_req, 0);

      $display("[TB] reset during ACCESS");
      applyStimulus(mk(1, 0, 3'b010, 32'h104, 32'h0, 32'hA5A50001, 0, 0, 0, 4'hF, 32'h0, 32'hA5A50001));
      @(negedge clk);
      memory_read = 1'b1; funct3 = 3'b010; address = 32'h104;
      #1;
      checkOutput("rst_write_done_idle", write_done, 0);
      @(negedge clk);
      #1;
      checkOutput("rst_req_access", bus.dmem_req, 1);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("rst_async_req", bus.dmem_req, 0);
      checkOutput("rst_async_load_data", load_data, 0);
      last_load = 32'd0;
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      checkOutput("rst_release_req", bus.dmem_req, 0);
      checkOutput("rst_release_write_done", write_done, 0);
      @(negedge clk);
      bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h0F0F1234;
      #1;
      checkOutput("rst_restart_req", bus.dmem_req, 1);
      @(negedge clk);
      bus.dmem_ack = 1'b0;
      #1;
      checkOutput("rst_restart_load_data", load_data, 32'h0F0F1234);
      checkOutput("rst_restart_write_done", write_done, 1);
      last_load = 32'h0F0F1234;
      @(negedge clk);
      memory_read = 1'b0;

      $display("[TB] randomized accesses");
      for (int n = 0; n < 40; n++) begin
         op      = $urandom_range(0, 2);
         v.rd    = (op != 1);
         v.wr    = (op != 0);
         v.f3    = 3'($urandom_range(0, 7));
         v.addr  = $urandom;
         v.sd    = $urandom;
         v.rdata = $urandom;
         v.waits = $urandom_range(0, 4);
         v = model(v);
         applyStimulus(v);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
